// File: rtl/calc_unit_scheduler.sv
// Arbitrates the calculator's shared add/sub and shift units between four ports.
// Each unit keeps an arrival-ordered FIFO; same-cycle arrivals are ordered round-robin.
module calc_unit_scheduler #(
    parameter int NPORTS = 4,
    parameter int CMDW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS*CMDW-1:0]   req_cmd,
    input  logic                     add_ready,
    input  logic                     shf_ready,
    output logic [NPORTS-1:0]        req_ack,
    output logic [NPORTS-1:0]        req_inv,
    output logic [NPORTS-1:0]        add_grant,
    output logic [NPORTS-1:0]        shf_grant,
    output logic [2:0]               add_qcnt,
    output logic [2:0]               shf_qcnt
);

    logic [1:0]        add_mem_q [4];
    logic [1:0]        add_mem_d [4];
    logic [1:0]        shf_mem_q [4];
    logic [1:0]        shf_mem_d [4];
    logic [1:0]        add_head_q, add_head_d, shf_head_q, shf_head_d;
    logic [2:0]        add_cnt_q, add_cnt_d, shf_cnt_q, shf_cnt_d;
    logic [NPORTS-1:0] pending_q, pending_d;
    logic [1:0]        rr_q, rr_d;
    logic [NPORTS-1:0] ack_q, ack_d, inv_q, inv_d;
    logic [NPORTS-1:0] add_gnt_q, add_gnt_d, shf_gnt_q, shf_gnt_d;

    logic [1:0]        port_s;
    logic [CMDW-1:0]   cmd_s;
    logic [2:0]        add_push_s, shf_push_s;
    logic [1:0]        waddr_s;
    logic              add_pop_s, shf_pop_s;
    logic              any_acc_s;
    logic [1:0]        last_s;

    assign req_ack   = ack_q;
    assign req_inv   = inv_q;
    assign add_grant = add_gnt_q;
    assign shf_grant = shf_gnt_q;
    assign add_qcnt  = add_cnt_q;
    assign shf_qcnt  = shf_cnt_q;

    // Next-state: pop FIFO heads, then classify and push new arrivals in rotation order.
    always_comb begin
        add_mem_d  = add_mem_q;
        shf_mem_d  = shf_mem_q;
        add_head_d = add_head_q;
        shf_head_d = shf_head_q;
        pending_d  = pending_q;
        ack_d      = 4'b0000;
        inv_d      = 4'b0000;
        add_gnt_d  = 4'b0000;
        shf_gnt_d  = 4'b0000;
        add_push_s = 3'd0;
        shf_push_s = 3'd0;
        waddr_s    = 2'd0;
        port_s     = 2'd0;
        cmd_s      = '0;
        any_acc_s  = 1'b0;
        last_s     = 2'd0;
        add_pop_s  = (add_cnt_q != 3'd0) && add_ready;
        shf_pop_s  = (shf_cnt_q != 3'd0) && shf_ready;

        if (add_pop_s) begin
            add_gnt_d[add_mem_q[add_head_q]] = 1'b1;
            pending_d[add_mem_q[add_head_q]] = 1'b0;
            add_head_d = add_head_q + 2'd1;
        end else begin
            add_head_d = add_head_q;
        end
        if (shf_pop_s) begin
            shf_gnt_d[shf_mem_q[shf_head_q]] = 1'b1;
            pending_d[shf_mem_q[shf_head_q]] = 1'b0;
            shf_head_d = shf_head_q + 2'd1;
        end else begin
            shf_head_d = shf_head_q;
        end

        // A granted port still reads as pending here, so a request on its grant edge is ignored.
        for (int i = 0; i < 4; i++) begin
            port_s = rr_q + 2'(i);
            cmd_s  = req_cmd[CMDW*int'(port_s) +: CMDW];
            if (req_valid[port_s] && !pending_q[port_s]) begin
                case (cmd_s)
                    4'd1, 4'd2: begin
                        waddr_s = add_head_q + add_cnt_q[1:0] + add_push_s[1:0];
                        add_mem_d[waddr_s] = port_s;
                        add_push_s = add_push_s + 3'd1;
                        ack_d[port_s]     = 1'b1;
                        pending_d[port_s] = 1'b1;
                        any_acc_s = 1'b1;
                        last_s    = port_s;
                    end
                    4'd5, 4'd6: begin
                        waddr_s = shf_head_q + shf_cnt_q[1:0] + shf_push_s[1:0];
                        shf_mem_d[waddr_s] = port_s;
                        shf_push_s = shf_push_s + 3'd1;
                        ack_d[port_s]     = 1'b1;
                        pending_d[port_s] = 1'b1;
                        any_acc_s = 1'b1;
                        last_s    = port_s;
                    end
                    4'd0: begin
                        inv_d[port_s] = 1'b0;
                    end
                    default: begin
                        inv_d[port_s] = 1'b1;
                    end
                endcase
            end else begin
                cmd_s = cmd_s;
            end
        end

        add_cnt_d = add_cnt_q + add_push_s - {2'b00, add_pop_s};
        shf_cnt_d = shf_cnt_q + shf_push_s - {2'b00, shf_pop_s};
        if (any_acc_s) begin
            rr_d = last_s + 2'd1;
        end else begin
            rr_d = rr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                add_mem_q[i] <= 2'd0;
                shf_mem_q[i] <= 2'd0;
            end
            add_head_q <= 2'd0;
            shf_head_q <= 2'd0;
            add_cnt_q  <= 3'd0;
            shf_cnt_q  <= 3'd0;
            pending_q  <= 4'b0000;
            rr_q       <= 2'd0;
            ack_q      <= 4'b0000;
            inv_q      <= 4'b0000;
            add_gnt_q  <= 4'b0000;
            shf_gnt_q  <= 4'b0000;
        end else begin
            add_mem_q  <= add_mem_d;
            shf_mem_q  <= shf_mem_d;
            add_head_q <= add_head_d;
            shf_head_q <= shf_head_d;
            add_cnt_q  <= add_cnt_d;
            shf_cnt_q  <= shf_cnt_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
            inv_q      <= inv_d;
            add_gnt_q  <= add_gnt_d;
            shf_gnt_q  <= shf_gnt_d;
        end
    end

endmodule

// File: tb/tb_calc_unit_scheduler.sv
// Directed-vector bench for calc_unit_scheduler; expected values are hand-computed.
module tb_calc_unit_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_cmd;
    logic        add_ready;
    logic        shf_ready;
    logic [3:0]  req_ack;
    logic [3:0]  req_inv;
    logic [3:0]  add_grant;
    logic [3:0]  shf_grant;
    logic [2:0]  add_qcnt;
    logic [2:0]  shf_qcnt;

    int n_cmp;
    int n_bad;

    calc_unit_scheduler #(.NPORTS(4), .CMDW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .add_ready (add_ready),
        .shf_ready (shf_ready),
        .req_ack   (req_ack),
        .req_inv   (req_inv),
        .add_grant (add_grant),
        .shf_grant (shf_grant),
        .add_qcnt  (add_qcnt),
        .shf_qcnt  (shf_qcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b0000; req_cmd = 16'h0000;
        add_ready = 1'b0; shf_ready = 1'b0;
        step(); step();
        n_cmp++;
        if ({req_ack, req_inv, add_grant, shf_grant} !== 16'h0000) begin
            $display("FAIL reset_out: got %h exp 0000", {req_ack, req_inv, add_grant, shf_grant}); n_bad++;
        end
        n_cmp++;
        if ({add_qcnt, shf_qcnt} !== 6'd0) begin
            $display("FAIL reset_qcnt: got %0d/%0d exp 0/0", add_qcnt, shf_qcnt); n_bad++;
        end
        req_valid = 4'b1111; req_cmd = 16'h5F21; add_ready = 1'b1; shf_ready = 1'b1;
        step();
        n_cmp++;
        if ({req_ack, req_inv, add_grant, shf_grant, add_qcnt, shf_qcnt} !== 22'd0) begin
            $display("FAIL reset_busy: ack %b inv %b ag %b sg %b q %0d/%0d exp all 0",
                     req_ack, req_inv, add_grant, shf_grant, add_qcnt, shf_qcnt); n_bad++;
        end
        reset = 1'b0; req_valid = 4'b0000; req_cmd = 16'h0000;
    endtask

    task automatic test_single_add();
        add_ready = 1'b1;
        req_valid = 4'b0100; req_cmd = 16'h0100;
        step();
        n_cmp++;
        if (req_ack !== 4'b0100 || add_grant !== 4'b0000 || add_qcnt !== 3'd1) begin
            $display("FAIL single_ack: ack %b grant %b q %0d exp 0100 0000 1", req_ack, add_grant, add_qcnt); n_bad++;
        end
        req_valid = 4'b0000; req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (add_grant !== 4'b0100 || req_ack !== 4'b0000 || add_qcnt !== 3'd0) begin
            $display("FAIL single_grant: grant %b ack %b q %0d exp 0100 0000 0", add_grant, req_ack, add_qcnt); n_bad++;
        end
        step();
        n_cmp++;
        if (add_grant !== 4'b0000) begin
            $display("FAIL single_pulse: grant %b exp 0000", add_grant); n_bad++;
        end
    endtask

    task automatic burst_four(input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3, input string tag);
        logic [3:0] exp_seq [4];
        exp_seq[0] = e0; exp_seq[1] = e1; exp_seq[2] = e2; exp_seq[3] = e3;
        req_valid = 4'b1111; req_cmd = 16'h2222;
        step();
        n_cmp++;
        if (req_ack !== 4'b1111 || add_qcnt !== 3'd4) begin
            $display("FAIL %s_push: ack %b q %0d exp 1111 4", tag, req_ack, add_qcnt); n_bad++;
        end
        req_valid = 4'b0000; req_cmd = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (add_grant !== exp_seq[i] || add_qcnt !== 3'(3 - i) || add_qcnt > 3'd4) begin
                $display("FAIL %s_grant%0d: grant %b q %0d exp %b %0d", tag, i, add_grant, add_qcnt, exp_seq[i], 3 - i);
                n_bad++;
            end
        end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1; step(); reset = 1'b0;
        add_ready = 1'b1;
        burst_four(4'b0001, 4'b0010, 4'b0100, 4'b1000, "rr0");
        // One accept from port 1 moves rr to 2.
        req_valid = 4'b0010; req_cmd = 16'h0010;
        step();
        req_valid = 4'b0000; req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (add_grant !== 4'b0010) begin
            $display("FAIL rr_setup: grant %b exp 0010", add_grant); n_bad++;
        end
        burst_four(4'b0100, 4'b1000, 4'b0001, 4'b0010, "rr2");
    endtask

    task automatic test_mixed();
        add_ready = 1'b1; shf_ready = 1'b1;
        req_valid = 4'b0011; req_cmd = 16'h0061;
        step();
        n_cmp++;
        if (req_ack !== 4'b0011 || add_qcnt !== 3'd1 || shf_qcnt !== 3'd1) begin
            $display("FAIL mixed_ack: ack %b q %0d/%0d exp 0011 1/1", req_ack, add_qcnt, shf_qcnt); n_bad++;
        end
        req_valid = 4'b0000; req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (add_grant !== 4'b0001 || shf_grant !== 4'b0010) begin
            $display("FAIL mixed_grant: ag %b sg %b exp 0001 0010", add_grant, shf_grant); n_bad++;
        end
    endtask

    task automatic test_invalid();
        req_valid = 4'b1000; req_cmd = 16'hF000;
        step();
        n_cmp++;
        if (req_inv !== 4'b1000 || req_ack !== 4'b0000 || add_qcnt !== 3'd0 || shf_qcnt !== 3'd0) begin
            $display("FAIL inv_pulse: inv %b ack %b q %0d/%0d exp 1000 0000 0/0", req_inv, req_ack, add_qcnt, shf_qcnt);
            n_bad++;
        end
        req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (req_inv !== 4'b0000 || req_ack !== 4'b0000) begin
            $display("FAIL nop: inv %b ack %b exp 0000 0000", req_inv, req_ack); n_bad++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_rerequest();
        add_ready = 1'b1;
        req_valid = 4'b0001; req_cmd = 16'h0001;
        step();
        n_cmp++;
        if (req_ack !== 4'b0001) begin
            $display("FAIL rereq_first: ack %b exp 0001", req_ack); n_bad++;
        end
        step();
        n_cmp++;
        if (add_grant !== 4'b0001 || req_ack !== 4'b0000) begin
            $display("FAIL rereq_grant_edge: grant %b ack %b exp 0001 0000", add_grant, req_ack); n_bad++;
        end
        step();
        n_cmp++;
        if (req_ack !== 4'b0001 || add_grant !== 4'b0000) begin
            $display("FAIL rereq_again: ack %b grant %b exp 0001 0000", req_ack, add_grant); n_bad++;
        end
        req_valid = 4'b0000; req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (add_grant !== 4'b0001) begin
            $display("FAIL rereq_second_grant: grant %b exp 0001", add_grant); n_bad++;
        end
    endtask

    task automatic test_backpressure();
        shf_ready = 1'b0;
        req_valid = 4'b1010; req_cmd = 16'h5050;
        step();
        n_cmp++;
        if (req_ack !== 4'b1010 || shf_qcnt !== 3'd2 || shf_grant !== 4'b0000) begin
            $display("FAIL bp_push: ack %b q %0d sg %b exp 1010 2 0000", req_ack, shf_qcnt, shf_grant); n_bad++;
        end
        req_valid = 4'b0010; req_cmd = 16'h0050;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (req_ack !== 4'b0000 || shf_qcnt !== 3'd2 || shf_grant !== 4'b0000) begin
                $display("FAIL bp_hold%0d: ack %b q %0d sg %b exp 0000 2 0000", i, req_ack, shf_qcnt, shf_grant);
                n_bad++;
            end
        end
        reset = 1'b1; req_valid = 4'b0000; req_cmd = 16'h0000;
        step();
        n_cmp++;
        if (shf_qcnt !== 3'd0 || add_qcnt !== 3'd0 || req_ack !== 4'b0000) begin
            $display("FAIL bp_reset: q %0d/%0d ack %b exp 0/0 0000", add_qcnt, shf_qcnt, req_ack); n_bad++;
        end
        reset = 1'b0; shf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (shf_grant !== 4'b0000 || shf_qcnt !== 3'd0) begin
                $display("FAIL bp_nogrant%0d: sg %b q %0d exp 0000 0", i, shf_grant, shf_qcnt); n_bad++;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_add();
        test_simultaneous();
        test_mixed();
        test_invalid();
        test_rerequest();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_unit_scheduler.md
Name: calc_unit_scheduler

Overview:
- Sequences access to the shared add/sub unit and the shared shift unit of the four-port calculator.
- Ports raise command requests. The scheduler classifies each one, queues it per unit in arrival order, and issues one-cycle grants when the unit is ready.
- Fairness rule: arrival order across cycles; rotating round-robin priority among same-cycle arrivals. Unknown commands are rejected.

Parameters:
- NPORTS, 4, number of requester ports (only 4 supported; port IDs are 2 bits).
- CMDW, 4, command field width per port.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  4  bit p = port p presents a command this cycle.
- req_cmd  input  16  port p command in bits [4p+3:4p].
- add_ready  input  1  add/sub unit can accept an operation this cycle.
- shf_ready  input  1  shift unit can accept an operation this cycle.
- req_ack  output  4  one-cycle pulse: port p request accepted and queued.
- req_inv  output  4  one-cycle pulse: port p command invalid, dropped.
- add_grant  output  4  one-hot, one-cycle grant of add/sub unit.
- shf_grant  output  4  one-hot, one-cycle grant of shift unit.
- add_qcnt  output  3  add/sub queue occupancy (0..4).
- shf_qcnt  output  3  shift queue occupancy (0..4).

Behaviour:
- All outputs are registered. The per-port pending flags are internal.
- Reset (synchronous, active-high), and on any edge with reset=1:
  - both queues emptied; pending flags cleared; round-robin pointer rr set to 0;
  - every output is 0.
  - Reset mid-operation drops all queued requests, and no grant is issued for them.
- Classification, for req_valid[p]=1 with pending[p]=0:
  - cmd 1 (add) or 2 (sub): add queue.
  - cmd 5 (lsh) or 6 (rsh): shift queue.
  - cmd 0: ignored, no ack and no inv.
  - any other cmd: req_inv[p]=1 next cycle, nothing queued.
- Pending ports: req_valid[p] with pending[p]=1 is ignored (no ack, no inv). The requester holds or retries.
- Acceptance at edge k:
  - entry pushed to the unit FIFO (2-bit port ID); pending[p] set;
  - req_ack[p]=1 during cycle k..k+1.
- Same-cycle arrivals to one unit: pushed in order rr, rr+1, rr+2, rr+3 (mod 4). rr then moves to (last accepted port + 1) mod 4. rr advances only on edges with at least one acceptance.
- Each FIFO has depth 4. Overflow is impossible because each port has at most one pending entry. The occupancy counts must never exceed 4, and the bench checks this.
- Grant at an edge, evaluated per unit independently:
  - if the FIFO is non-empty and the unit ready input is sampled at 1: pop the head, assert the one-hot grant for that port for exactly one cycle, clear pending[head].
  - at most one grant per unit per edge;
  - add and shift grants may be issued at the same edge to different ports.
- Minimum latency: a request accepted at edge k into an empty queue with ready=1 is granted at edge k+1.
- Same-edge push and pop: an entry pushed at edge k is not visible to the pop at edge k. Occupancy updates as count + pushes - pop.
- Re-request: pending[p] clears at the grant edge. A new request from p is accepted at the earliest on the edge after the grant edge; a req_valid sampled on the grant edge itself is ignored.
- Ready low: the queue holds and the grant stays 0. There is no timeout.
- Ordering invariant: within one unit, grants follow the FIFO push order exactly.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req_valid=0 -> all outputs 0, qcnt 0/0; reset=1 with any inputs forces 0 again.
- Single add: port 2 cmd=1 at edge 1, add_ready=1 -> req_ack=4'b0100 after edge 1, add_grant=4'b0100 after edge 2, add_qcnt returns to 0.
- Simultaneous arrivals: ports 0..3 all cmd=2 at the same edge with rr=0 and add_ready=1 -> add_grant sequence 0001, 0010, 0100, 1000 on consecutive cycles. Repeated with rr=2 -> sequence 0100, 1000, 0001, 0010.
- Mixed units: port 0 cmd=1 and port 1 cmd=6 at the same edge, both readys=1 -> add_grant=0001 and shf_grant=0010 in the same cycle.
- Invalid and NOP: port 3 cmd=4'hF -> req_inv=1000 for 1 cycle, qcnt unchanged. Port 3 cmd=0 -> no ack, no inv.
- Backpressure and reset mid-operation: shf_ready=0 while ports 1 and 3 queue cmd=5 (shf_qcnt=2, no grants). Pending port 1 re-asserting is ignored. Then reset=1 for one edge -> qcnt=0; after shf_ready=1, no grant appears.
